ps2_rx_ctrl: RTL

//  Sequencer for the ps2_receiver. Gates receiver enable, takes each 11-bit frame,

---
 rtl/ps2_rx_ctrl_if.sv | 23 ++
 rtl/ps2_rx_ctrl.sv | 120 ++++++++++++
 2 files changed

// File: rtl/ps2_rx_ctrl_if.sv
// ps2_rx_ctrl_if: receiver-side and consumer-side signals of the PS/2 receive sequencer.
interface ps2_rx_ctrl_if;
    logic        rx_busy;
    logic        rx_done;
    logic [10:0] rx_frame;
    logic        rx_en;
    logic        rx_abort;
    logic        key_valid;
    logic        key_ready;
    logic [7:0]  key_code;
    logic        key_ext;
    logic        key_brk;
    logic        frame_err;
    logic        timeout_err;
    modport master (
        input  rx_busy, rx_done, rx_frame, key_ready,
        output rx_en, rx_abort, key_valid, key_code, key_ext, key_brk, frame_err, timeout_err
    );
    modport slave (
        output rx_busy, rx_done, rx_frame, key_ready,
        input  rx_en, rx_abort, key_valid, key_code, key_ext, key_brk, frame_err, timeout_err
    );
endinterface

// File: rtl/ps2_rx_ctrl.sv
// ps2_rx_ctrl: validates PS/2 frames, folds E0/F0 prefixes into one key event, watchdogs stalled frames.
module ps2_rx_ctrl #(
    parameter int TIMEOUT_CYC = 200000,
    parameter int CNT_W       = 18
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    ps2_rx_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, LISTEN, CHECK, HOLD} state_t;
    state_t             r_state, w_state;
    logic [10:0]        r_frame, w_frame;
    logic               r_ext_f, w_ext_f, r_brk_f, w_brk_f;
    logic [CNT_W-1:0]   r_cnt, w_cnt;
    logic               r_rx_en, r_abort, w_abort, r_valid, w_valid, r_ferr, w_ferr;
    logic [7:0]         r_code, w_code;
    logic               r_kext, w_kext, r_kbrk, w_kbrk;
    logic               w_good, w_tmo;
    logic [7:0]         w_data;
    assign w_data = r_frame[8:1];
    assign w_good = ~r_frame[0] & r_frame[10] & (^r_frame[9:1]);
    assign w_tmo  = r_cnt == CNT_W'(TIMEOUT_CYC - 1);
    always_comb begin
        w_state = r_state;
        w_frame = r_frame;
        w_ext_f = r_ext_f;
        w_brk_f = r_brk_f;
        w_cnt   = r_cnt;
        w_valid = r_valid;
        w_code  = r_code;
        w_kext  = r_kext;
        w_kbrk  = r_kbrk;
        w_abort = 1'b0;
        w_ferr  = 1'b0;
        case (r_state)
            IDLE: w_state = LISTEN;
            LISTEN: begin
                // a completed frame beats a watchdog expiry in the same cycle
                if (bus.rx_done) begin
                    w_frame = bus.rx_frame;
                    w_cnt   = '0;
                    w_state = CHECK;
                end else if (!bus.rx_busy) begin
                    w_cnt = '0;
                end else if (w_tmo) begin
                    w_abort = 1'b1;
                    w_cnt   = '0;
                    w_ext_f = 1'b0;
                    w_brk_f = 1'b0;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            CHECK: begin
                w_state = LISTEN;
                if (!w_good) begin
                    w_ferr  = 1'b1;
                    w_ext_f = 1'b0;
                    w_brk_f = 1'b0;
                end else if (w_data == 8'hE0) begin
                    w_ext_f = 1'b1;
                end else if (w_data == 8'hF0) begin
                    w_brk_f = 1'b1;
                end else begin
                    w_code  = w_data;
                    w_kext  = r_ext_f;
                    w_kbrk  = r_brk_f;
                    w_valid = 1'b1;
                    w_ext_f = 1'b0;
                    w_brk_f = 1'b0;
                    w_state = HOLD;
                end
            end
            HOLD: begin
                if (r_valid && bus.key_ready) begin
                    w_valid = 1'b0;
                    w_state = LISTEN;
                end
            end
            default: w_state = IDLE;
        endcase
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_frame <= '0;
            r_ext_f <= 1'b0;
            r_brk_f <= 1'b0;
            r_cnt   <= '0;
            r_rx_en <= 1'b0;
            r_abort <= 1'b0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_code  <= '0;
            r_kext  <= 1'b0;
            r_kbrk  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_frame <= w_frame;
            r_ext_f <= w_ext_f;
            r_brk_f <= w_brk_f;
            r_cnt   <= w_cnt;
            r_rx_en <= w_state == LISTEN;
            r_abort <= w_abort;
            r_valid <= w_valid;
            r_ferr  <= w_ferr;
            r_code  <= w_code;
            r_kext  <= w_kext;
            r_kbrk  <= w_kbrk;
        end
    end
    assign bus.rx_en       = r_rx_en;
    assign bus.rx_abort    = r_abort;
    assign bus.timeout_err = r_abort;
    assign bus.key_valid   = r_valid;
    assign bus.key_code    = r_code;
    assign bus.key_ext     = r_kext;
    assign bus.key_brk     = r_kbrk;
    assign bus.frame_err   = r_ferr;
endmodule
